// File: rtl/rgb_fader.sv
// rtl/rgb_fader.sv - jumps or linearly fades three 8-bit PWM levels toward a commanded 24-bit colour
// Optional gamma mapping on the duty outputs is enabled by defining RGB_FADER_GAMMA_EN.
module rgb_fader #(
    parameter int unsigned TICK_DIV = 390625,
    parameter int unsigned STEP     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_rgb,
    input  logic        cmd_instant,
    output logic [7:0]  duty_r,
    output logic [7:0]  duty_g,
    output logic [7:0]  duty_b,
    output logic        busy
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FADE = 1'b1
    } state_t;

    localparam logic [23:0] PRESC_LAST = 24'(TICK_DIV - 1);
    localparam logic [8:0]  STEP9      = 9'(STEP);

    state_t          state_q, state_d;
    logic [2:0][7:0] lvl_q, lvl_d;
    logic [2:0][7:0] tgt_q, tgt_d;
    logic [2:0][7:0] stepped;
    logic [2:0][7:0] duty_q, duty_d;
    logic [23:0]     presc_q, presc_d;

    // Moves one channel by min(STEP, |tgt-lvl|) toward tgt; 9-bit math keeps it from wrapping.
    function automatic logic [7:0] step_toward(input logic [7:0] lvl, input logic [7:0] tgt);
        logic [8:0] diff;
        logic [8:0] d;
        diff = (tgt > lvl) ? ({1'b0, tgt} - {1'b0, lvl}) : ({1'b0, lvl} - {1'b0, tgt});
        d    = (diff < STEP9) ? diff : STEP9;
        return (tgt > lvl) ? 8'({1'b0, lvl} + d) : 8'({1'b0, lvl} - d);
    endfunction

    function automatic logic [7:0] duty_map(input logic [7:0] x);
`ifdef RGB_FADER_GAMMA_EN
        logic [15:0] prod;
        prod = 16'(x) * (16'(x) + 16'd1);
        return prod[15:8];
`else
        return x;
`endif
    endfunction

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        tgt_d   = tgt_q;
        presc_d = presc_q;
        for (int c = 0; c < 3; c++) begin
            stepped[c] = step_toward(lvl_q[c], tgt_q[c]);
            duty_d[c]  = duty_map(lvl_q[c]);
        end
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    tgt_d = cmd_rgb;
                    if (cmd_instant) begin
                        lvl_d = cmd_rgb;
                    end else if (cmd_rgb != lvl_q) begin
                        presc_d = 24'd0;
                        state_d = ST_FADE;
                    end
                end
            end
            ST_FADE: begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = 24'd0;
                    lvl_d   = stepped;
                    if (stepped == tgt_q) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    presc_d = presc_q + 24'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lvl_q   <= '0;
            tgt_q   <= '0;
            presc_q <= '0;
            duty_q  <= '0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            tgt_q   <= tgt_d;
            presc_q <= presc_d;
            duty_q  <= duty_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_FADE);
    assign duty_r    = duty_q[2];
    assign duty_g    = duty_q[1];
    assign duty_b    = duty_q[0];
endmodule

// File: doc/rgb_fader.md
# rgb_fader

Upstream control stage for the three `pwm_driver` channels of the RGB mixer. It accepts a 24-bit target colour over a valid/ready handshake and either jumps to it or ramps each channel linearly toward it at a programmable rate. Its registered 8-bit levels drive `duty_cycle` of the red, green and blue `pwm_driver` instances.

## Interface
Parameters:
- `TICK_DIV`, default 390625: clock cycles per fade step (~3.9 ms at 100 MHz). Legal range is 1 to 2^24-1.
- `STEP`, default 1: maximum level change per channel per fade step. Legal range is 1 to 255.

Ports:
- Clocking and reset:
  - `clk` input 1: system clock; every register is clocked on its rising edge.
  - `rst` input 1: synchronous, active-high reset.
- Command handshake:
  - `cmd_valid` input 1: a command is present.
  - `cmd_ready` output 1: the block can accept a command.
  - `cmd_rgb` input 24: target colour; R = [23:16], G = [15:8], B = [7:0].
  - `cmd_instant` input 1: 1 = jump to the target, 0 = fade to it.
- Outputs:
  - `duty_r`, `duty_g`, `duty_b` output 8 each: duty values to the pwm_drivers.
  - `busy` output 1: a fade is in progress.

## Operation
- Internal state:
  - `lvl_r/g/b` [7:0]: current levels.
  - `tgt_r/g/b` [7:0]: target levels.
  - `presc` [23:0]: step prescaler.
  - FSM with states IDLE and FADE.
- IDLE:
  - `cmd_ready` = 1.
  - On an edge where `cmd_valid & cmd_ready`, `tgt` is loaded from `cmd_rgb`.
  - If `cmd_instant` = 1: `lvl` is loaded from `cmd_rgb` on the same edge, and the FSM stays in IDLE.
  - Else if `cmd_rgb` equals the current `lvl` on all three channels: the FSM stays in IDLE.
  - Otherwise: `presc` is cleared to 0 and the FSM goes to FADE.
- FADE:
  - `cmd_ready` = 0 and `busy` = 1. `cmd_valid` is ignored; the command is not consumed.
  - `presc` increments by 1 each cycle.
  - When `presc` == TICK_DIV-1, on that edge:
    - `presc` returns to 0.
    - Each channel moves by d = min(STEP, |tgt-lvl|), up if tgt > lvl, down if tgt < lvl. It never overshoots and never wraps.
    - If the updated levels equal `tgt` on all channels, the FSM goes to IDLE on the same edge.
- Channels move independently. A channel already at its target does not change while the others continue.
- Arithmetic:
  - Level arithmetic uses 9 bits internally.
  - Results are always within 0..255 by the min() rule above.

## Timing
- Reset, applied at any time (including mid-fade):
  - FSM goes to IDLE; `lvl`, `tgt` and `presc` are cleared to 0.
  - `duty_r/g/b` = 0, `busy` = 0.
  - `cmd_ready` = 1 from the first cycle after `rst` deasserts.
- `duty_x` is a register loaded from f(`lvl_x`) each cycle, so it lags `lvl` by exactly 1 cycle.
  - f is the identity, or the gamma mapping in Configuration.
- Instant command accepted at edge E: `lvl` is updated at E and `duty` at E+1.
- Fade command accepted at edge E:
  - The first level step occurs at edge E+TICK_DIV; step k occurs at E+k·TICK_DIV.
  - `busy` rises after edge E.
  - `busy` falls and `cmd_ready` rises after the final step edge. A new command can be accepted at the next edge.
- Worst-case fade length: ceil(255/STEP)·TICK_DIV cycles.
- `cmd_ready` and `busy` are registered-state decodes; they have no combinational path from `cmd_valid`.

## Configuration
- Macro `RGB_FADER_GAMMA_EN`.
- Defined: f(x) = (x·(x+1)) >> 8, computed as a 16-bit product. This gives f(0)=0, f(1)=0, f(128)=64, f(255)=255, and f is monotonic.
- Undefined: f(x) = x, and no multiplier is synthesised.
- The mapping affects only `duty_*`. `lvl`, the fade stepping and the handshake are identical in both builds.

## Test plan
The bench uses TICK_DIV=4 and STEP=1 unless stated otherwise.
- Reset, then check idle outputs -> `duty_r/g/b` = 0, `busy` = 0, `cmd_ready` = 1.
- Instant command 0x4080FF, gamma off -> one cycle after acceptance, `duty_r/g/b` = 64/128/255; `busy` stays 0 throughout.
- Fade from 0 to 0x030000 -> `duty_r` steps 1, 2, 3 at 4-cycle intervals.
  - Each step appears 1 cycle after edges E+4, E+8 and E+12.
  - `busy` is high for exactly 12 cycles; a `cmd_valid` asserted during the fade is not accepted until `cmd_ready` returns.
- STEP=100, fade 0x000000 -> 0xFF00FA, then fade -> 0x000000:
  - Up: R goes 100, 200, 255; B goes 100, 200, 250.
  - Down: R goes 155, 55, 0; B goes 150, 50, 0.
  - No wrap on either channel.
- Assert `rst` mid-fade, then release it -> all outputs are 0 on the cycle after the reset edge; a subsequent instant command 0x010101 is accepted normally.
- With `RGB_FADER_GAMMA_EN` defined, instant commands 0x80FF01 then 0x000000 -> `duty` = 64/255/0, then 0/0/0.
